// File: rtl/irq_pending_latch_if.sv
// Bus between the interrupt pending latch and its surroundings (raw lines,
// mask, priority encoder feedback and the consumer's irq/ack handshake).
interface irq_pending_latch_if #(
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
);
  logic [WIDTH-1:0] irq_raw;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] req;
  logic [ID_W-1:0]  enc_pos;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic             ack;
  logic [WIDTH-1:0] pending;
  logic             timeout;

  // The system side: raw sources, mask, encoder and interrupt consumer.
  modport master (
    output irq_raw, mask, enc_pos, ack,
    input  req, irq, irq_id, pending, timeout
  );

  // The latch itself.
  modport slave (
    input  irq_raw, mask, enc_pos, ack,
    output req, irq, irq_id, pending, timeout
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Sticky rising-edge interrupt capture feeding a priority encoder, presenting one
// interrupt at a time with irq/ack and an ack timeout. Optional: IRQ_SYNC_EN.
module irq_pending_latch #(
  parameter int WIDTH       = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  irq_pending_latch_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam int               TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit               TMR_EN   = (ACK_TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] raw_q;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] pending_q;
  logic [0:0]       state_q;
  logic             irq_q;
  logic [ID_W-1:0]  irq_id_q;
  logic [TMR_W-1:0] timer_q;
  logic             timeout_q;
  logic             tmo_hit;

`ifdef IRQ_SYNC_EN
  logic [WIDTH-1:0] sync_ff1;
  logic [WIDTH-1:0] sync_ff2;

  // Two-flop synchronizer per line for asynchronous interrupt sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= bus.irq_raw;
      sync_ff2 <= sync_ff1;
    end
  end

  assign raw_s = sync_ff2;
`else
  assign raw_s = bus.irq_raw;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) raw_q <= '0;
    else     raw_q <= raw_s;
  end

  assign set_vec = raw_s & ~raw_q;

  // NOTE: every signal driven from always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    clr_vec = '0;
    tmo_hit = 1'b0;
    if (state_q == ACTIVE) begin
      if (bus.ack)
        clr_vec = WIDTH'(1) << irq_id_q;
      else if (TMR_EN && (timer_q == TMR_LAST))
        tmo_hit = 1'b1;
    end
  end

  // Set is ORed in after the clear, so a new edge in the ack cycle keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= (pending_q & ~clr_vec) | set_vec;
  end

  // irq is registered alongside the state, so irq=1 exactly while ACTIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            irq_id_q <= bus.enc_pos;
            timer_q  <= '0;
            irq_q    <= 1'b1;
            state_q  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.ack) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            irq_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (TMR_EN) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req     = pending_q & ~bus.mask;
  assign bus.pending = pending_q;
  assign bus.irq     = irq_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch with a highest-index-wins encoder model
// closing the req -> enc_pos loop.
module tb_irq_pending_latch;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  irq_pending_latch_if #(.WIDTH(4), .ID_W(2)) bus ();

  irq_pending_latch #(
    .WIDTH      (4),
    .ID_W       (2),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Priority encoder: highest set request bit wins.
  always_comb begin
    bus.enc_pos = '0;
    for (int i = 0; i < 4; i++)
      if (bus.req[i]) bus.enc_pos = 2'(i);
  end

  always @(posedge clk) begin
    if (!rst && !bus.irq && (|bus.req))
      assert (bus.req[bus.enc_pos]) else $error("encoder fault: req=%b pos=%0d", bus.req, bus.enc_pos);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] t3_ids [4];
    int cnt;
    int pres;
    logic prev;

    t3_ids = '{2'd3, 2'd2, 2'd1, 2'd0};
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.irq_raw = '0;
    bus.mask    = '0;
    bus.ack     = 1'b0;

    repeat (2) tick();
    check("rst_irq",     bus.irq,     0);
    check("rst_pending", bus.pending, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_req",     bus.req,     0);
    check("rst_irq_id",  bus.irq_id,  0);
    rst = 1'b0;
    tick();
    check("idle_irq", bus.irq, 0);

    // Single pulse on line 2.
    bus.irq_raw = 4'b0100;
    tick();
    bus.irq_raw = 4'b0000;
    check("t2_pending", bus.pending, 4'b0100);
    check("t2_irq_early", bus.irq, 0);
    tick();
    check("t2_irq", bus.irq, 1);
    check("t2_id",  bus.irq_id, 2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("t2_pending_clr", bus.pending, 0);
    check("t2_irq_drop",    bus.irq, 0);
    tick();

    // All four lines at once: four presentations with one-cycle gaps.
    bus.irq_raw = 4'b1111;
    tick();
    check("t3_pending", bus.pending, 4'b1111);
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_irq%0d", k), bus.irq, 1);
      check($sformatf("t3_id%0d", k),  bus.irq_id, t3_ids[k]);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      check($sformatf("t3_gap%0d", k), bus.irq, 0);
      tick();
    end
    check("t3_irq_end",     bus.irq, 0);
    check("t3_pending_end", bus.pending, 0);
    bus.irq_raw = 4'b0000;
    tick();

    // Masked line is captured but not requested; ack while idle is ignored.
    bus.mask    = 4'b0010;
    bus.irq_raw = 4'b0010;
    tick();
    bus.irq_raw = 4'b0000;
    check("t4_pending", bus.pending, 4'b0010);
    check("t4_req",     bus.req, 0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("t4_irq_masked",  bus.irq, 0);
    check("t4_ack_ignored", bus.pending, 4'b0010);
    tick();
    check("t4_irq_still0", bus.irq, 0);
    bus.mask = 4'b0000;
    tick();
    check("t4_irq", bus.irq, 1);
    check("t4_id",  bus.irq_id, 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("t4_pending_clr", bus.pending, 0);
    tick();

    // Ack timeout on line 3.
    bus.irq_raw = 4'b1000;
    tick();
    bus.irq_raw = 4'b0000;
    tick();
    check("t5_irq", bus.irq, 1);
    check("t5_id",  bus.irq_id, 3);
    cnt = 0;
    while (bus.irq && cnt < 40) begin
      cnt++;
      tick();
    end
    check("t5_irq_cycles", cnt, 16);
    check("t5_irq_drop",   bus.irq, 0);
    check("t5_timeout",    bus.timeout, 1);
    check("t5_pending",    bus.pending, 4'b1000);
    tick();
    check("t5_repres",    bus.irq, 1);
    check("t5_repres_id", bus.irq_id, 3);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("t5_pending_clr", bus.pending, 0);
    check("t5_timeout_sticky", bus.timeout, 1);
    tick();

    // New edge on line 0 in the ack cycle of id 0: set wins.
    bus.irq_raw = 4'b0001;
    tick();
    bus.irq_raw = 4'b0000;
    tick();
    check("t6_irq", bus.irq, 1);
    check("t6_id",  bus.irq_id, 0);
    bus.ack     = 1'b1;
    bus.irq_raw = 4'b0001;
    tick();
    bus.ack = 1'b0;
    check("t6_set_wins", bus.pending, 4'b0001);
    check("t6_gap",      bus.irq, 0);
    tick();
    check("t6_repres",    bus.irq, 1);
    check("t6_repres_id", bus.irq_id, 0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("t6_level_no_reset", bus.pending, 0);
    bus.irq_raw = 4'b0000;
    tick();
    tick();

    // Level held high for 20 cycles gives a single presentation.
    bus.irq_raw = 4'b0001;
    pres = 0;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.irq && !prev) pres++;
      prev    = bus.irq;
      bus.ack = bus.irq;
    end
    bus.ack = 1'b0;
    check("t6_level_pres",    pres, 1);
    check("t6_level_pending", bus.pending, 0);
    bus.irq_raw = 4'b0000;
    tick();

    // Asynchronous reset while ACTIVE with another line pending.
    bus.mask    = 4'b0010;
    bus.irq_raw = 4'b0110;
    tick();
    bus.irq_raw = 4'b0000;
    tick();
    check("t1_irq_pre",     bus.irq, 1);
    check("t1_id_pre",      bus.irq_id, 2);
    check("t1_timeout_pre", bus.timeout, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_irq_async",     bus.irq, 0);
    check("t1_pending_async", bus.pending, 0);
    check("t1_timeout_async", bus.timeout, 0);
    bus.mask = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t1_post_irq%0d", i), bus.irq, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
